// File: rtl/quick_spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : quick_spi_pkg                                        |
// | Description : Shared state encoding, default timeouts and sizing   |
// |               helpers for the quick_spi arbiter slice.             |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package quick_spi_pkg;

  // Arbiter state encoding
  localparam logic [2:0] ARB_IDLE      = 3'd0;
  localparam logic [2:0] ARB_ISSUE     = 3'd1;
  localparam logic [2:0] ARB_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ARB_WAIT_DONE = 3'd3;
  localparam logic [2:0] ARB_GAP       = 3'd4;

  // Default timing
  localparam int DEF_START_TIMEOUT = 8;
  localparam int DEF_DONE_TIMEOUT  = 1024;
  localparam int DEF_GAP_CYCLES    = 2;

  // Smallest r with 2**r >= value
  function automatic int qs_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int qs_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quick_spi_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : quick_spi_rr_picker                                  |
// | Description : Combinational round-robin picker. Scans upward from  |
// |               rr_ptr+1 with wrap and returns the first requester.  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module quick_spi_rr_picker
  import quick_spi_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]           req_i,
  input  logic [qs_clog2(NUM_REQUESTERS)-1:0] rr_ptr_i,
  output logic [qs_clog2(NUM_REQUESTERS)-1:0] winner_o,
  output logic                                valid_o
);

  localparam int c_id_w = qs_clog2(NUM_REQUESTERS);

  // (base + off) mod N, valid for base < N and off <= N
  function automatic logic [c_id_w-1:0] wrap_idx(input logic [c_id_w-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQUESTERS) s = s - NUM_REQUESTERS;
    return c_id_w'(s);
  endfunction

  // Walk from the farthest offset down so the nearest requester is the last writer
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = NUM_REQUESTERS; k >= 1; k--) begin
      if (req_i[wrap_idx(rr_ptr_i, k)]) begin
        winner_o = wrap_idx(rr_ptr_i, k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/quick_spi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : quick_spi_arbiter                                    |
// | Description : Round-robin sharing of one quick_spi master between  |
// |               several clients, with start/done timeouts and        |
// |               per-client ack/done/error pulses.                    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module quick_spi_arbiter
  import quick_spi_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int SLAVE_IDX_WIDTH = 1,
  parameter int START_TIMEOUT   = DEF_START_TIMEOUT,
  parameter int DONE_TIMEOUT    = DEF_DONE_TIMEOUT,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [NUM_REQUESTERS-1:0]                  req_i,
  input  logic [NUM_REQUESTERS*SLAVE_IDX_WIDTH-1:0]  req_slave_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]       req_data_i,
  output logic [NUM_REQUESTERS-1:0]                  ack_o,
  output logic [NUM_REQUESTERS-1:0]                  done_o,
  output logic [NUM_REQUESTERS-1:0]                  error_o,
  output logic                                       spi_start_o,
  output logic [SLAVE_IDX_WIDTH-1:0]                 spi_slave_o,
  output logic [DATA_WIDTH-1:0]                      spi_data_o,
  input  logic                                       spi_busy_i,
  output logic                                       active_o,
  output logic [qs_clog2(NUM_REQUESTERS)-1:0]        grant_id_o
);

  localparam int c_gnt_w = qs_clog2(NUM_REQUESTERS);
  localparam int c_cnt_w = qs_clog2(qs_max(qs_max(START_TIMEOUT, DONE_TIMEOUT), GAP_CYCLES)) + 1;
  localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_done_last  = c_cnt_w'(DONE_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(GAP_CYCLES - 1);
  // Pointer starts at the top client so client 0 wins the first scan
  localparam logic [c_gnt_w-1:0] c_rr_init    = c_gnt_w'(NUM_REQUESTERS - 1);

  logic [2:0]                  state_q, state_d;
  logic [c_cnt_w-1:0]          cnt_q, cnt_d;
  logic [c_gnt_w-1:0]          rr_q, rr_d;
  logic [c_gnt_w-1:0]          gnt_q, gnt_d;
  logic [SLAVE_IDX_WIDTH-1:0]  slave_q, slave_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [NUM_REQUESTERS-1:0]   ack_q, ack_d;
  logic [NUM_REQUESTERS-1:0]   done_q, done_d;
  logic [NUM_REQUESTERS-1:0]   err_q, err_d;
  logic                        start_q, start_d;

  logic [c_gnt_w-1:0]          w_pick;
  logic                        w_pick_valid;
  logic [SLAVE_IDX_WIDTH-1:0]  w_slave_arr [NUM_REQUESTERS];
  logic [DATA_WIDTH-1:0]       w_data_arr  [NUM_REQUESTERS];

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_unpack
    assign w_slave_arr[g] = req_slave_i[g*SLAVE_IDX_WIDTH +: SLAVE_IDX_WIDTH];
    assign w_data_arr[g]  = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  quick_spi_rr_picker #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_picker (
    .req_i    (req_i),
    .rr_ptr_i (rr_q),
    .winner_o (w_pick),
    .valid_o  (w_pick_valid)
  );

  // Next-state logic: grant, issue, wait for busy rise/fall with timeouts, then gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    slave_d = slave_q;
    data_d  = data_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          state_d       = ARB_ISSUE;
          gnt_d         = w_pick;
          rr_d          = w_pick;
          slave_d       = w_slave_arr[w_pick];
          data_d        = w_data_arr[w_pick];
          ack_d[w_pick] = 1'b1;
          start_d       = 1'b1;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (spi_busy_i) begin
          state_d = ARB_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == c_start_last) begin
          err_d[gnt_q] = 1'b1;
          state_d      = ARB_GAP;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_WAIT_DONE: begin
        // Busy falling is checked first so it beats a coincident timeout
        if (!spi_busy_i) begin
          done_d[gnt_q] = 1'b1;
          state_d       = ARB_GAP;
          cnt_d         = '0;
        end else if (cnt_q == c_done_last) begin
          err_d[gnt_q] = 1'b1;
          state_d      = ARB_GAP;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_GAP: begin
        if (cnt_q == c_gap_last) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction silently
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      rr_q    <= c_rr_init;
      gnt_q   <= '0;
      slave_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      slave_q <= slave_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign ack_o       = ack_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign spi_start_o = start_q;
  assign spi_slave_o = slave_q;
  assign spi_data_o  = data_q;
  assign grant_id_o  = gnt_q;
  assign active_o    = (state_q != ARB_IDLE);

endmodule
`default_nettype wire
